mem_port_arbiter: RTL

// Shares one fixed-latency data memory port between two requesters (client 0: instruction-side cache,

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_port_arbiter_rr_pick2.sv | 32 +++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

  typedef logic client_t;

  localparam int CLIENTS = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: lone requester wins, contention goes to the client not served last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       g
);

  logic r_last;

  always_comb begin
    case (req)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
      2'b11:   g = ~r_last;
      default: g = 1'b0;
    endcase
  end

  // Reset to client 1 so that client 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (update) begin
      r_last <= g;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between an I-cache and a D-cache, one access in flight.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int NA    = 6,
  parameter int LAT   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] req,
  input  logic [CLIENTS-1:0] we,
  input  logic [NA-1:0]      addr0,
  input  logic [NA-1:0]      addr1,
  input  logic [NBITS-1:0]   wdata0,
  input  logic [NBITS-1:0]   wdata1,
  output logic [NBITS-1:0]   rdata,
  output logic [CLIENTS-1:0] done,
  output logic [NA-1:0]      memAddress,
  output logic [NBITS-1:0]   memWriteData,
  input  logic [NBITS-1:0]   memReadData,
  output logic               memMemWrite
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  arb_state_t    r_state;
  logic [CW-1:0] r_cnt;
  client_t       r_gnt;
  logic          w_start;
  logic          w_g;

  assign w_start = (r_state == IDLE) && (req != 2'b00);

  rr_pick2 u_pick (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .update (w_start),
    .g      (w_g)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_gnt        <= 1'b0;
      rdata        <= '0;
      done         <= '0;
      memAddress   <= '0;
      memWriteData <= '0;
      memMemWrite  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= '0;
          if (w_start) begin
            memAddress   <= w_g ? addr1 : addr0;
            memWriteData <= w_g ? wdata1 : wdata0;
            memMemWrite  <= we[w_g];
            r_cnt        <= CNT_LOAD;
            r_gnt        <= w_g;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          // The write strobe doubles as the read/write flag for the access in flight.
          if (r_cnt == '0) begin
            if (!memMemWrite) begin
              rdata <= memReadData;
            end
            memMemWrite <= 1'b0;
            done        <= r_gnt ? 2'b10 : 2'b01;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          done    <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
